// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-fetch, data and shared-memory signals that pass
// between the CPU/memory side and mem_arbiter.
//   master : the arbiter's view (it drives the shared memory port and acks)
//   slave  : the environment's view (requesters plus the memory itself)
interface mem_arbiter_if;
  // instruction fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  // data port
  logic        d_r;
  logic        d_w;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  // shared single-port memory
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // status
  logic        stall;
  logic        bus_err;

  modport master (
    input  if_req, if_addr, d_r, d_w, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr,
           mem_wdata, stall, bus_err
  );

  modport slave (
    output if_req, if_addr, d_r, d_w, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr,
           mem_wdata, stall, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port
// and a data port. Data has fixed priority. Each access is granted, held on
// the memory bus until mem_ack (or a wait-cycle timeout), then acknowledged
// to its requester with a one-cycle pulse from the RESP state.
module mem_arbiter #(
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  // The wait counter is 4 bits wide, so TIMEOUT is limited to 1..15.
  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [3:0]  wait_cnt_next;
  logic        mem_req_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] if_rdata_reg;
  logic [31:0] d_rdata_reg;
  logic        if_ack_reg;
  logic        d_ack_reg;
  logic        bus_err_reg;

  assign wait_cnt_next = wait_cnt_reg + 4'd1;

  // Arbitration FSM: grant, wait for memory (or time out), acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      if_rdata_reg  <= 32'd0;
      d_rdata_reg   <= 32'd0;
      if_ack_reg    <= 1'b0;
      d_ack_reg     <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      // Acks are high only during the single RESP cycle.
      if_ack_reg <= 1'b0;
      d_ack_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Requester inputs are sampled only here, on the grant edge.
          // A simultaneous read+write is granted as a write.
          if (bus.d_r || bus.d_w) begin
            state_reg     <= DATA;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= bus.d_w;
            mem_addr_reg  <= bus.d_addr;
            mem_wdata_reg <= bus.d_wdata;
            wait_cnt_reg  <= 4'd0;
          end else if (bus.if_req) begin
            state_reg     <= FETCH;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= bus.if_addr;
            mem_wdata_reg <= 32'd0;
            wait_cnt_reg  <= 4'd0;
          end
        end
        FETCH, DATA: begin
          // Memory bus fields are left untouched here so they stay stable.
          if (bus.mem_ack) begin
            if (state_reg == DATA) begin
              d_rdata_reg <= bus.mem_rdata;
              d_ack_reg   <= 1'b1;
            end else begin
              if_rdata_reg <= bus.mem_rdata;
              if_ack_reg   <= 1'b1;
            end
            mem_req_reg <= 1'b0;
            state_reg   <= RESP;
          end else if (wait_cnt_next == TIMEOUT_CNT) begin
            // Memory never answered: complete with the error pattern.
            if (state_reg == DATA) begin
              d_rdata_reg <= ERR_DATA;
              d_ack_reg   <= 1'b1;
            end else begin
              if_rdata_reg <= ERR_DATA;
              if_ack_reg   <= 1'b1;
            end
            wait_cnt_reg <= wait_cnt_next;
            bus_err_reg  <= 1'b1;
            mem_req_reg  <= 1'b0;
            state_reg    <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
          end
        end
        RESP: begin
          // Requests and stray mem_acks are ignored while acknowledging.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.if_ack    = if_ack_reg;
  assign bus.d_ack     = d_ack_reg;
  assign bus.bus_err   = bus_err_reg;
  // Stall the pipeline whenever something is pending and not being acked now.
  assign bus.stall     = (bus.if_req | bus.d_r | bus.d_w) & ~(if_ack_reg | d_ack_reg);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory bursts
// and expected acks into queues; a monitor pops and compares them whenever
// the DUT starts a memory burst or pulses an ack.
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;     // expected mem_req length in cycles, 0 = unchecked
  } mem_exp_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
  } ack_exp_t;

  typedef struct {
    int          wait_n;  // wait cycles before mem_ack
    logic [31:0] rdata;
  } mem_item_t;

  logic clk;
  logic rst_n;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT (15),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int bursts = 0;
  int stray_req = 0;
  int stray_served = 0;

  mem_exp_t  exp_mem_q[$];
  ack_exp_t  exp_ack_q[$];
  mem_item_t mem_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: answers each burst with the next queued item.
  initial begin
    mem_item_t cur;
    bit        have_item;
    int        rcnt;
    have_item     = 0;
    rcnt          = 0;
    cur           = '{99, 32'h0};
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.mem_req) begin
        have_item = 0;
        rcnt      = 0;
        if (stray_served != stray_req) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 32'hFFFFFFFF;
          stray_served++;
        end else begin
          bus.mem_ack = 1'b0;
        end
      end else begin
        if (!have_item) begin
          if (mem_q.size() > 0) cur = mem_q.pop_front();
          else cur = '{99, 32'h0};
          have_item = 1;
        end
        if (rcnt == cur.wait_n) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = cur.rdata;
        end else begin
          bus.mem_ack = 1'b0;
        end
        rcnt++;
      end
    end
  end

  // Monitor: memory bursts and acks against the scoreboard queues.
  initial begin
    mem_exp_t cur_mem;
    ack_exp_t e;
    bit       cur_valid;
    bit       prev_req;
    bit       prev_ack;
    int       burst_len;
    cur_valid = 0;
    prev_req  = 0;
    prev_ack  = 0;
    burst_len = 0;
    cur_mem   = '{1'b0, 32'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (!prev_req) begin
          bursts++;
          burst_len = 0;
          if (exp_mem_q.size() == 0) begin
            checks++;
            errors++;
            cur_valid = 0;
            $display("FAIL unexpected_burst: actual addr=%h required no burst", bus.mem_addr);
          end else begin
            cur_mem   = exp_mem_q.pop_front();
            cur_valid = 1;
          end
        end
        burst_len++;
        if (cur_valid) begin
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, cur_mem.we});
          chk("mem_addr", bus.mem_addr, cur_mem.addr);
          chk("mem_wdata", bus.mem_wdata, cur_mem.wdata);
        end
      end else if (prev_req) begin
        if (cur_valid && cur_mem.len != 0) chk("burst_len", burst_len, cur_mem.len);
      end
      prev_req = bus.mem_req;

      if (bus.if_ack || bus.d_ack) begin
        if (prev_ack) begin
          checks++;
          errors++;
          $display("FAIL ack_width: actual=2+ cycles required=1 cycle");
        end
        if (bus.if_ack && bus.d_ack) begin
          checks++;
          errors++;
          $display("FAIL dual_ack: actual=both acks required=one ack");
        end
        if (exp_ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: actual if_ack=%b d_ack=%b required none", bus.if_ack, bus.d_ack);
        end else begin
          e = exp_ack_q.pop_front();
          chk("ack_port", {31'd0, bus.d_ack}, {31'd0, e.is_data});
          chk("ack_rdata", e.is_data ? bus.d_rdata : bus.if_rdata, e.rdata);
          chk("ack_bus_err", {31'd0, bus.bus_err}, {31'd0, e.err});
          $display("ack %s rdata=%h bus_err=%b", bus.d_ack ? "data " : "fetch",
                   bus.d_ack ? bus.d_rdata : bus.if_rdata, bus.bus_err);
        end
      end
      prev_ack = bus.if_ack | bus.d_ack;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Requester side: wait for an ack, check stall, drop the acked request.
  task automatic wait_ack(input int max, output int lat);
    lat = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      lat++;
      if (bus.if_ack || bus.d_ack) begin
        chk("stall_at_ack", {31'd0, bus.stall}, 32'd0);
        if (bus.if_ack) bus.if_req = 1'b0;
        if (bus.d_ack) begin
          bus.d_r = 1'b0;
          bus.d_w = 1'b0;
        end
        return;
      end
      chk("stall_wait", {31'd0, bus.stall}, 32'd1);
    end
    checks++;
    errors++;
    $display("FAIL ack_wait: actual=no ack in %0d cycles required=ack", max);
    bus.if_req = 1'b0;
    bus.d_r    = 1'b0;
    bus.d_w    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int b0;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_r     = 1'b0;
    bus.d_w     = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_if_ack", {31'd0, bus.if_ack}, 32'd0);
    chk("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
    chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fetch: mem_ack in the first FETCH cycle, latency 3.
    mem_q.push_back('{0, 32'h24080005});
    exp_mem_q.push_back('{1'b0, 32'h00400000, 32'h0, 1});
    exp_ack_q.push_back('{1'b0, 32'h24080005, 1'b0});
    sync();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h00400000;
    wait_ack(10, lat);
    chk("fetch_latency", lat, 32'd3);

    // Write with two memory wait cycles: bus held 3 cycles, latency 5.
    mem_q.push_back('{2, 32'h11112222});
    exp_mem_q.push_back('{1'b1, 32'h10010004, 32'hCAFEF00D, 3});
    exp_ack_q.push_back('{1'b1, 32'h11112222, 1'b0});
    sync();
    bus.d_w     = 1'b1;
    bus.d_addr  = 32'h10010004;
    bus.d_wdata = 32'hCAFEF00D;
    wait_ack(10, lat);
    chk("write_latency", lat, 32'd5);

    // Contention: data served first, then fetch, one burst each.
    mem_q.push_back('{1, 32'h8C0A0010});
    mem_q.push_back('{1, 32'h014B4820});
    exp_mem_q.push_back('{1'b0, 32'h10010008, 32'h0, 2});
    exp_mem_q.push_back('{1'b0, 32'h00400004, 32'h0, 2});
    exp_ack_q.push_back('{1'b1, 32'h8C0A0010, 1'b0});
    exp_ack_q.push_back('{1'b0, 32'h014B4820, 1'b0});
    sync();
    b0 = bursts;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h00400004;
    bus.d_r     = 1'b1;
    bus.d_addr  = 32'h10010008;
    bus.d_wdata = 32'h0;
    wait_ack(10, lat);
    chk("contention_data_latency", lat, 32'd4);
    wait_ack(10, lat);
    chk("contention_fetch_latency", lat, 32'd4);
    sync();
    chk("contention_bursts", bursts - b0, 32'd2);

    // Timeout: memory never answers, 15 wait cycles then error data.
    mem_q.push_back('{99, 32'h0});
    exp_mem_q.push_back('{1'b0, 32'h10010010, 32'h0, 15});
    exp_ack_q.push_back('{1'b1, 32'hDEADBEEF, 1'b1});
    sync();
    bus.d_r    = 1'b1;
    bus.d_addr = 32'h10010010;
    wait_ack(40, lat);
    chk("timeout_latency", lat, 32'd17);

    // Normal fetch afterwards: bus_err stays set.
    mem_q.push_back('{0, 32'h8FA40000});
    exp_mem_q.push_back('{1'b0, 32'h00400008, 32'h0, 1});
    exp_ack_q.push_back('{1'b0, 32'h8FA40000, 1'b1});
    sync();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h00400008;
    wait_ack(10, lat);
    chk("post_timeout_fetch_latency", lat, 32'd3);

    // Stray mem_ack in IDLE: no ack, no burst, rdata registers untouched.
    sync();
    sync();
    stray_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("stray_no_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
    end
    chk("stray_if_rdata", bus.if_rdata, 32'h8FA40000);
    chk("stray_d_rdata", bus.d_rdata, 32'hDEADBEEF);

    // Simultaneous read and write is a write.
    mem_q.push_back('{0, 32'h55AA55AA});
    exp_mem_q.push_back('{1'b1, 32'h10010020, 32'h12345678, 1});
    exp_ack_q.push_back('{1'b1, 32'h55AA55AA, 1'b1});
    sync();
    bus.d_r     = 1'b1;
    bus.d_w     = 1'b1;
    bus.d_addr  = 32'h10010020;
    bus.d_wdata = 32'h12345678;
    wait_ack(10, lat);
    chk("dual_latency", lat, 32'd3);

    // Reset in the middle of a DATA access: aborted, no ack.
    mem_q.push_back('{99, 32'h0});
    exp_mem_q.push_back('{1'b0, 32'h10010030, 32'h0, 0});
    sync();
    bus.d_r     = 1'b1;
    bus.d_addr  = 32'h10010030;
    bus.d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("pre_reset_mem_req", {31'd0, bus.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset_d_ack", {31'd0, bus.d_ack}, 32'd0);
    chk("reset_bus_err", {31'd0, bus.bus_err}, 32'd0);
    chk("reset_d_rdata", bus.d_rdata, 32'h0);
    bus.d_r = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_reset_no_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);

    // Re-issued request completes normally with bus_err cleared.
    mem_q.push_back('{0, 32'h600DF00D});
    exp_mem_q.push_back('{1'b0, 32'h10010030, 32'h0, 1});
    exp_ack_q.push_back('{1'b1, 32'h600DF00D, 1'b0});
    sync();
    bus.d_r    = 1'b1;
    bus.d_addr = 32'h10010030;
    wait_ack(10, lat);
    chk("reissue_latency", lat, 32'd3);

    repeat (3) @(negedge clk);
    chk("acks_outstanding", exp_ack_q.size(), 32'd0);
    chk("bursts_outstanding", exp_mem_q.size(), 32'd0);
    chk("mem_items_left", mem_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 The block SHALL have the following parameters:
  - TIMEOUT, default 15: maximum number of wait cycles for mem_ack, range 1..15.
  - ERR_DATA, default 32'hDEADBEEF: read data returned to the requester on a timeout.
REQ-003 The block SHALL have the following ports:
  - clk  in  1  clock.
  - rst_n  in  1  asynchronous active-low reset.
  - if_req  in  1  instruction fetch request, level, held until if_ack.
  - if_addr  in  32  fetch address, stable while if_req is high.
  - if_rdata  out  32  fetched instruction, valid while if_ack is high.
  - if_ack  out  1  one-cycle pulse, fetch complete.
  - d_r  in  1  data read request, level, held until d_ack.
  - d_w  in  1  data write request, level, held until d_ack.
  - d_addr  in  32  data address.
  - d_wdata  in  32  store data.
  - d_rdata  out  32  load data, valid while d_ack is high.
  - d_ack  out  1  one-cycle pulse, data access complete.
  - mem_req  out  1  request to the shared single-port memory.
  - mem_we  out  1  write enable for the shared memory.
  - mem_addr  out  32  shared memory address.
  - mem_wdata  out  32  shared memory write data.
  - mem_rdata  in  32  shared memory read data, valid when mem_ack is high.
  - mem_ack  in  1  one-cycle memory completion.
  - stall  out  1  hold PC/regfile write; combinational.
  - bus_err  out  1  sticky timeout flag.

Function
REQ-004 The FSM SHALL have four states: IDLE, FETCH, DATA and RESP.
REQ-005 In IDLE, the FSM SHALL go to DATA when d_r or d_w is high; otherwise to FETCH when if_req is high; otherwise it SHALL stay in IDLE. Data has fixed priority over fetch.
REQ-006 On entry to FETCH or DATA, the block SHALL register mem_addr, mem_we (d_w for DATA, 0 for FETCH) and mem_wdata (d_wdata for DATA, 0 for FETCH), and set mem_req=1. The requester's inputs are sampled only on that grant edge.
REQ-007 mem_req, mem_addr, mem_we and mem_wdata SHALL stay constant while in FETCH or DATA.
REQ-008 In FETCH or DATA, when mem_ack=1 the block SHALL capture mem_rdata into the granted requester's rdata register, drop mem_req, and go to RESP.
REQ-009 In RESP, the block SHALL pulse the granted ack (if_ack or d_ack) high for exactly one cycle, then return to IDLE; requests are ignored while in RESP.
REQ-010 The minimum latency from a request in IDLE to its ack SHALL be 3 cycles (grant, mem_ack in the first FETCH/DATA cycle, RESP).
REQ-011 A 4-bit wait counter SHALL clear on grant and increment each FETCH/DATA cycle without mem_ack. When it reaches TIMEOUT, the block SHALL:
  - load ERR_DATA into the granted rdata register;
  - set bus_err;
  - drop mem_req;
  - go to RESP.
REQ-012 bus_err SHALL remain set until reset.
REQ-013 If d_r and d_w are both high at grant, the access SHALL be treated as a write. d_rdata is then updated with mem_rdata as for any access.
REQ-014 A mem_ack that arrives in IDLE or RESP SHALL be ignored.
REQ-015 if_rdata and d_rdata SHALL hold their last value between acks.
REQ-016 stall SHALL be high when (if_req | d_r | d_w) is high and neither if_ack nor d_ack is high in the same cycle.
REQ-017 A requester whose request is raised while the other requester is being served SHALL wait in turn; no request SHALL be lost or served twice, provided the requester drops its request the cycle after its ack.

Reset
REQ-018 While rst_n=0, the block SHALL asynchronously force:
  - state to IDLE;
  - mem_req, mem_we, if_ack, d_ack and bus_err to 0;
  - mem_addr, mem_wdata, if_rdata, d_rdata and the wait counter to 0.
REQ-019 A reset asserted mid-transaction SHALL abort it with no ack, and mem_req SHALL drop in the same cycle.
REQ-020 After rst_n rises, the first grant SHALL occur no earlier than the first clk edge.

Verification
REQ-021 Fetch test: if_req=1, if_addr=0x0040_0000, mem_ack one cycle after mem_req with mem_rdata=0x2408_0005. Required response:
  - mem_we=0;
  - if_ack one cycle later with if_rdata=0x2408_0005;
  - total latency 3 cycles;
  - stall high until the ack cycle.
REQ-022 Write test: d_w=1, d_addr=0x1001_0004, d_wdata=0xCAFE_F00D, memory acks after 2 wait cycles. Required response:
  - mem_we=1, mem_addr=0x1001_0004, mem_wdata=0xCAFE_F00D, held stable for 3 cycles;
  - d_ack one cycle after mem_ack.
REQ-023 Contention test: if_req and d_r raised in the same cycle. Required response:
  - DATA is served first (d_ack);
  - then FETCH (if_ack);
  - exactly one mem_req burst per access.
REQ-024 Timeout test: d_r=1 with mem_ack tied to 0 and TIMEOUT=15. Required response:
  - mem_req drops after 15 wait cycles;
  - d_ack pulses with d_rdata=0xDEADBEEF;
  - bus_err=1 and stays set through later normal fetches.
REQ-025 Reset test: rst_n pulled low while in DATA with mem_req=1. Required response:
  - mem_req=0 immediately;
  - no d_ack;
  - bus_err=0;
  - a re-issued request after reset completes normally.
REQ-026 Late-ack and dual-request test:
  - a stray mem_ack while in IDLE produces no ack;
  - d_r=d_w=1 produces a write access (mem_we=1).
